// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter and sequences instruction fetch, one fetch at a
// time, over a valid/ready instruction bus. The fetched word is presented to
// decode and held under a stall handshake. Branch and trap redirects kill any
// in-flight fetch.
//
// Handshake semantics:
//   ireq_valid/ireq_ready : the address on ireq_addr is accepted on a rising
//     edge where both are 1. Until acceptance the address may change (this
//     happens only when a redirect arrives while a request is pending).
//   iresp_valid : one-cycle pulse carrying the word for the accepted address.
//     There is no back-pressure on the response side.
//   inst_valid/stall : decode takes the instruction on a rising edge where
//     inst_valid=1 and stall=0. While stall=1 the instruction stays put.
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   stall                    decode cannot accept this cycle
//   br_valid, br_target      branch/jump redirect
//   trap_valid, trap_target  trap/return redirect (wins over branch)
//   ireq_valid, ireq_addr    fetch request (address is always pc)
//   ireq_ready               bus accepted the request
//   iresp_valid, iresp_data  returned instruction word
//   inst_valid, inst, inst_pc  instruction to decode
//   pc                       current fetch PC
//   state_dbg                current FSM state (for checkers)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              XLEN    = 64,
  parameter logic [XLEN-1:0] PC_INIT = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            ireq_ready,
  input  logic            iresp_valid,
  input  logic [31:0]     iresp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;  // request on the bus
  localparam logic [2:0] S_WAIT  = 3'd2;  // accepted, waiting for data
  localparam logic [2:0] S_HOLD  = 3'd3;  // instruction presented to decode
  localparam logic [2:0] S_FLUSH = 3'd4;  // waiting for a killed fetch's data

  logic [2:0]      state;
  logic            redirect;
  logic [XLEN-1:0] redirect_sel;
  logic [XLEN-1:0] redirect_pc;

  assign redirect     = trap_valid | br_valid;
  assign redirect_sel = trap_valid ? trap_target : br_target;
  // Instructions are word aligned; the low two target bits are dropped.
  assign redirect_pc  = redirect_sel & ~XLEN'(3);

  assign ireq_valid = (state == S_REQ);
  assign ireq_addr  = pc;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= PC_INIT;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Redirects cannot be pending this early; start fetching.
          state <= S_REQ;
        end

        S_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            // If the bus took the stale address this edge, its data must be
            // waited out and thrown away; otherwise simply re-aim the request.
            state <= ireq_ready ? S_FLUSH : S_REQ;
          end else if (ireq_ready) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            pc    <= redirect_pc;
            // Data arriving together with the redirect is stale: drop it.
            state <= iresp_valid ? S_REQ : S_FLUSH;
          end else if (iresp_valid) begin
            inst       <= iresp_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            // Held instruction is on the wrong path; no sequential advance.
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end else if (!stall) begin
            inst_valid <= 1'b0;
            pc         <= pc + XLEN'(4);
            state      <= S_REQ;
          end
        end

        S_FLUSH: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          // The killed fetch's data ends the flush. A redirect landing on the
          // same edge only re-aims pc; leaving FLUSH is still required because
          // no further response will ever arrive.
          if (iresp_valid) begin
            state <= S_REQ;
          end
        end

        default: begin
          state      <= S_IDLE;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A small memory responder answers each
// accepted request after a programmable delay with a word derived from its
// address. A transaction-level model tracks the expected pc, whether a fetch is
// outstanding (and whether it was killed), and the instruction held for decode;
// a compare process checks every DUT output against it on each falling edge.
// Directed steps add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int          XLEN    = 64;
  localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            stall;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            ireq_ready;
  logic            iresp_valid;
  logic [31:0]     iresp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc;
  logic [2:0]      state_dbg;

  fetch_sequencer #(.XLEN(XLEN), .PC_INIT(PC_INIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .ireq_ready  (ireq_ready),
    .iresp_valid (iresp_valid),
    .iresp_data  (iresp_data),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc          (pc),
    .state_dbg   (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // ---------------- memory responder / driver ----------------
  bit          k_ready   = 1'b1;
  int          mem_delay = 1;
  int          resp_cnt  = 0;
  logic [63:0] resp_addr = '0;

  // Advance to the next falling edge: one-shot redirects drop, the responder
  // produces its data pulse and decides acceptance for the coming edge.
  task automatic tick();
    @(negedge clk);
    br_valid    = 1'b0;
    trap_valid  = 1'b0;
    iresp_valid = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          iresp_valid = 1'b1;
          iresp_data  = inst_of(resp_addr);
        end
      end
      ireq_ready = k_ready;
      if (ireq_valid && ireq_ready) begin
        resp_cnt  = mem_delay;
        resp_addr = ireq_addr;
      end
    end
  endtask

  task automatic wait_req(string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ireq_valid) return;
    end
    n_checks++;
    $display("FAIL %s: timeout waiting for ireq_valid", tag);
  endtask

  task automatic wait_inst(string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (inst_valid) return;
    end
    n_checks++;
    $display("FAIL %s: timeout waiting for inst_valid", tag);
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_pc;
  logic        m_started;
  logic        m_out;    // a fetch has been accepted and not yet answered
  logic        m_kill;   // that fetch's data must be discarded
  logic        m_held;   // an instruction is waiting for decode
  logic [31:0] m_inst;
  logic [63:0] m_ipc;
  logic        m_req;

  assign m_req = m_started && !m_out && !m_held;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc      <= PC_INIT;
      m_started <= 1'b0;
      m_out     <= 1'b0;
      m_kill    <= 1'b0;
      m_held    <= 1'b0;
      m_inst    <= '0;
      m_ipc     <= '0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else begin : step
      logic        redir;
      logic [63:0] tgt;
      redir = trap_valid || br_valid;
      tgt   = trap_valid ? trap_target : br_target;
      tgt[1:0] = 2'b00;
      if (m_req) begin
        if (ireq_ready) begin
          m_out  <= 1'b1;
          m_kill <= redir;
        end
        if (redir) m_pc <= tgt;
      end else if (m_out) begin
        if (iresp_valid) begin
          m_out  <= 1'b0;
          m_kill <= 1'b0;
          if (!m_kill && !redir) begin
            m_held <= 1'b1;
            m_inst <= iresp_data;
            m_ipc  <= m_pc;
          end
        end else if (redir) begin
          m_kill <= 1'b1;
        end
        if (redir) m_pc <= tgt;
      end else if (m_held) begin
        if (redir) begin
          m_held <= 1'b0;
          m_pc   <= tgt;
        end else if (!stall) begin
          m_held <= 1'b0;
          m_pc   <= m_pc + 64'd4;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_ireq_valid", 64'(ireq_valid), 64'(m_req));
      check("cyc_ireq_addr",  ireq_addr, m_pc);
      check("cyc_pc",         pc, m_pc);
      check("cyc_inst_valid", 64'(inst_valid), 64'(m_held));
      check("cyc_inst",       64'(inst), 64'(m_inst));
      check("cyc_inst_pc",    inst_pc, m_ipc);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] held_inst;
  logic [63:0] held_pc;

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    br_valid    = 1'b0;
    br_target   = '0;
    trap_valid  = 1'b0;
    trap_target = '0;
    ireq_ready  = 1'b1;
    iresp_valid = 1'b0;
    iresp_data  = '0;

    tick();
    cmp_en = 1'b1;
    tick();

    // Reset state
    check("rst_pc",         pc, PC_INIT);
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst",       64'(inst), 64'd0);
    check("rst_inst_pc",    inst_pc, 64'd0);
    reset = 1'b0;

    // Sequential fetch with 1-cycle memory
    wait_req("seq0");
    check("seq0_addr", ireq_addr, 64'h8000_0000);
    wait_inst("seq0");
    check("seq0_inst",    64'(inst), 64'h0000_0013);
    check("seq0_inst_pc", inst_pc, 64'h8000_0000);
    tick();
    check("seq0_pulse",  64'(inst_valid), 64'd0);
    check("seq1_addr",   ireq_addr, 64'h8000_0004);
    wait_inst("seq1");
    check("seq1_inst",    64'(inst), 64'h0000_0413);
    check("seq1_inst_pc", inst_pc, 64'h8000_0004);
    tick();
    check("seq2_addr", ireq_addr, 64'h8000_0008);

    // Stall in HOLD for 4 cycles
    stall = 1'b1;
    wait_inst("stall");
    held_inst = inst;
    held_pc   = inst_pc;
    check("stall_inst_pc", held_pc, 64'h8000_0008);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 64'(inst_valid), 64'd1);
      check("stall_inst",  64'(inst), 64'(held_inst));
      check("stall_req",   64'(ireq_valid), 64'd0);
    end
    stall     = 1'b0;
    mem_delay = 2;
    tick();
    check("stall_next_addr", ireq_addr, 64'h8000_000C);

    // Branch during WAIT, data two cycles after acceptance
    tick();
    check("br_wait_state", 64'(state_dbg), 64'd2);
    br_valid  = 1'b1;
    br_target = 64'h8000_0103;
    tick();
    check("br_flush_state", 64'(state_dbg), 64'd4);
    check("br_flush_pc",    pc, 64'h8000_0100);
    check("br_flush_req",   64'(ireq_valid), 64'd0);
    check("br_flush_resp",  64'(iresp_valid), 64'd1);
    mem_delay = 1;
    tick();
    check("br_drop_valid", 64'(inst_valid), 64'd0);
    check("br_next_addr",  ireq_addr, 64'h8000_0100);

    // Trap and branch together in HOLD: trap wins
    wait_inst("prio");
    check("prio_inst", 64'(inst), 64'h0001_0013);
    trap_valid  = 1'b1;
    trap_target = 64'h8000_0200;
    br_valid    = 1'b1;
    br_target   = 64'h8000_0300;
    tick();
    check("prio_pc",    pc, 64'h8000_0200);
    check("prio_valid", 64'(inst_valid), 64'd0);
    check("prio_addr",  ireq_addr, 64'h8000_0200);

    // Async reset in the middle of WAIT
    tick();
    check("arst_wait", 64'(state_dbg), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("arst_pc",         pc, PC_INIT);
    check("arst_inst_valid", 64'(inst_valid), 64'd0);
    check("arst_ireq_valid", 64'(ireq_valid), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    wait_req("arst_restart");
    check("arst_restart_addr", ireq_addr, PC_INIT);

    // Wrap of pc+4 at the top of the address space
    wait_inst("wrap_a");
    trap_valid  = 1'b1;
    trap_target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    check("wrap_top_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_inst("wrap_b");
    check("wrap_inst",    64'(inst), 64'hFFFF_FC13);
    check("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_zero_addr", ireq_addr, 64'd0);

    // Redirect while a request waits for ireq_ready
    wait_inst("nordy");
    k_ready = 1'b0;
    tick();
    check("nordy_addr", ireq_addr, 64'd4);
    br_valid  = 1'b1;
    br_target = 64'h0000_0000_0000_1001;
    tick();
    check("nordy_req",    64'(ireq_valid), 64'd1);
    check("nordy_retgt",  ireq_addr, 64'h1000);
    k_ready = 1'b1;
    wait_inst("nordy_done");
    check("nordy_inst_pc", inst_pc, 64'h1000);

    // Redirect on the edge the bus accepts the stale request
    tick();
    check("acc_addr", ireq_addr, 64'h1004);
    br_valid  = 1'b1;
    br_target = 64'h2000;
    tick();
    check("acc_flush", 64'(state_dbg), 64'd4);
    check("acc_pc",    pc, 64'h2000);
    tick();
    check("acc_next_addr", ireq_addr, 64'h2000);
    wait_inst("acc_done");
    check("acc_inst",    64'(inst), 64'h0020_0013);
    check("acc_inst_pc", inst_pc, 64'h2000);

    tick();
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the program counter and sequences instruction fetch over a valid/ready instruction bus.
- Selects next PC from sequential (+4), branch redirect or trap redirect.
- Tracks and kills in-flight fetches on redirect, and presents fetched instructions to decode under a stall handshake.
- Sits between the instruction memory interface and the IF/ID pipeline register.

Parameters:
- XLEN, 64, PC and address width.
- PC_INIT, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  decode cannot accept an instruction this cycle.
- br_valid  input  1  branch/jump redirect request.
- br_target  input  XLEN  branch target.
- trap_valid  input  1  trap/exception/return redirect request.
- trap_target  input  XLEN  trap target.
- ireq_valid  output  1  fetch request valid.
- ireq_addr  output  XLEN  fetch address (= pc).
- ireq_ready  input  1  bus accepted the address this cycle.
- iresp_valid  input  1  fetch data returned this cycle.
- iresp_data  input  32  fetched instruction word.
- inst_valid  output  1  instruction valid to decode.
- inst  output  32  instruction to decode.
- inst_pc  output  XLEN  PC of inst.
- pc  output  XLEN  current fetch PC.

Behaviour:
- Reset (async, any state): pc=PC_INIT, state=IDLE, ireq_valid=0, inst_valid=0, inst=0, inst_pc=0.
- States: IDLE, REQ, WAIT, HOLD, FLUSH. All outputs are registered except ireq_valid, which equals (state==REQ), and ireq_addr, which equals pc.
- IDLE: on the first rising edge with reset low, go to REQ.
- REQ: ireq_valid=1. If ireq_ready=1, go to WAIT; otherwise stay in REQ.
- WAIT: on iresp_valid=1, latch inst=iresp_data, inst_pc=pc, set inst_valid=1, go to HOLD.
- HOLD: inst, inst_pc and inst_valid stay stable while stall=1. On the first cycle with stall=0, the handoff occurs: next cycle inst_valid=0, pc=pc+4 (mod 2^64), state=REQ.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with 1-cycle memory.
- stall affects only HOLD. Fetch in REQ/WAIT proceeds regardless of stall.
- Redirect: asserted when trap_valid | br_valid. trap_valid has priority over br_valid. The target has bits [1:0] cleared. The redirect is honoured regardless of stall. Next cycle: pc=target, inst_valid=0. State transition depends on the current state:
  - IDLE: ignored (cannot occur after reset).
  - REQ with ireq_ready=0: stay REQ; ireq_addr changes to the target (bus permits address change before acceptance).
  - REQ with ireq_ready=1: go to FLUSH (the stale request was accepted).
  - WAIT with iresp_valid=0: go to FLUSH.
  - WAIT with iresp_valid=1: drop the data, go to REQ.
  - HOLD: go to REQ; the held instruction is discarded and no pc+4 occurs.
  - FLUSH: stay FLUSH; pc is updated to the new target.
- FLUSH: ireq_valid=0. On iresp_valid=1, discard the data and go to REQ. inst_valid stays 0.
- At most one fetch is outstanding. No request is issued in WAIT or FLUSH.
- pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.

Test Plan:
- Reset, then 1-cycle memory returning 32'h0000_0013, stall=0 -> ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive REQ cycles; inst_valid pulses for 1 cycle each with inst_pc matching.
- stall=1 for 4 cycles in HOLD -> inst and inst_pc stable, inst_valid=1 throughout, no new ireq_valid; after stall drops, next ireq_addr = previous+4.
- br_valid with br_target=0x8000_0103 during WAIT, response 2 cycles later -> state FLUSH, response discarded (inst_valid stays 0), next ireq_addr = 0x8000_0100.
- trap_valid (0x8000_0200) and br_valid (0x8000_0300) in the same cycle in HOLD -> pc=0x8000_0200, inst_valid=0 next cycle, next fetch at 0x8000_0200.
- reset asserted mid-WAIT, asynchronously between edges -> pc=0x8000_0000, inst_valid=0, ireq_valid=0 immediately; fetch restarts from PC_INIT after reset release.
- Force pc to 64'hFFFF_FFFF_FFFF_FFFC via trap and complete one handoff -> next ireq_addr = 0.
